// File: rtl/result_digit_serializer.sv
// rtl/result_digit_serializer.sv - binary to BCD double-dabble converter emitting decimal digits MSD first
// Optional macro ZERO_PAD_EN: emit every digit including leading zeros instead of suppressing them.
module result_digit_serializer #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] value_i,
  output logic              busy_o,
  output logic [7:0]        digit_o,
  output logic              digit_valid_o,
  input  logic              digit_ready_i,
  output logic              last_o,
  output logic              done_o
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] TOP_IDX    = IDX_W'(NUM_DIGITS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

`ifdef ZERO_PAD_EN
  localparam logic ZERO_PAD = 1'b1;
`else
  localparam logic ZERO_PAD = 1'b0;
`endif

  logic [1:0]        state_q,   state_d;
  logic [DATA_W-1:0] shift_q,   shift_d;
  logic [BCD_W-1:0]  bcd_q,     bcd_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic              seen_q,    seen_d;

  logic [BCD_W-1:0]  bcd_adj;
  logic [3:0]        cur_nibble;
  logic              skip_digit;
  logic              emit_valid;
  logic              xfer;

  always_comb begin
    cur_nibble = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_nibble = bcd_q[4*i +: 4];
    end
  end

  // Add-3 is applied per nibble independently; a corrected nibble never exceeds 12, so no carry.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // With zero padding seen_q starts set, so skips never occur.
  always_comb begin
    skip_digit = !seen_q && (idx_q != '0) && (cur_nibble == 4'd0);
    emit_valid = (state_q == S_EMIT) && !skip_digit;
    xfer       = emit_valid && digit_ready_i;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    seen_d    = seen_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          shift_d   = value_i;
          bcd_d     = '0;
          bit_cnt_d = '0;
          idx_d     = TOP_IDX;
          seen_d    = ZERO_PAD;
          state_d   = S_CONVERT;
        end
      end
      S_CONVERT: begin
        bcd_d     = {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};
        shift_d   = {shift_q[DATA_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_SHIFT) begin
          idx_d   = TOP_IDX;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (skip_digit) begin
          idx_d = idx_q - IDX_W'(1);
        end else if (xfer) begin
          seen_d = 1'b1;
          if (idx_q == '0) state_d = S_DONE;
          else             idx_d   = idx_q - IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      seen_q    <= seen_d;
    end
  end

  // Outputs depend only on registered state, never on digit_ready_i.
  assign busy_o        = (state_q != S_IDLE);
  assign digit_valid_o = emit_valid;
  assign digit_o       = emit_valid ? {4'b0000, cur_nibble} : 8'd0;
  assign last_o        = emit_valid && (idx_q == '0);
  assign done_o        = (state_q == S_DONE);

endmodule
